// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into one event per key
// and queues {ext,brk,code} events in a first-word-fall-through FIFO.
module ps2_scan_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic       Clk_K,
    input  logic       Reset_K,
    input  logic       Rx_Done,
    input  logic [7:0] ps2_Rx,
    input  logic       Key_Ready,
    input  logic       Overflow_Clr,
    output logic       Key_Valid,
    output logic [7:0] Key_Code,
    output logic       Key_Ext,
    output logic       Key_Break,
    output logic       Fifo_Full,
    output logic       Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  to_cnt;
    logic           timeout_hit;
    logic           is_e0, is_f0, is_err;
    logic           push_req, push, pop;
    key_evt_t       push_evt, head;
    key_evt_t       mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [AW:0]    count;

    assign is_e0  = (ps2_Rx == 8'hE0);
    assign is_f0  = (ps2_Rx == 8'hF0);
    assign is_err = (ps2_Rx == 8'h00) || (ps2_Rx == 8'hFF);
    assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST);

    always_ff @(posedge Clk_K or negedge Reset_K) begin
        if (!Reset_K) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (Rx_Done || state == IDLE || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        push_req      = 1'b0;
        push_evt.ext  = (state == EXT) || (state == EXT_BRK);
        push_evt.brk  = (state == BRK) || (state == EXT_BRK);
        push_evt.code = ps2_Rx;
        if (Rx_Done) begin
            unique case (1'b1)
                is_err: state_nxt = IDLE;
                is_e0:  state_nxt = push_evt.brk ? EXT_BRK : EXT;
                is_f0:  state_nxt = push_evt.ext ? EXT_BRK : BRK;
                default: begin
                    push_req  = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end else if (timeout_hit) begin
            state_nxt = IDLE;
        end
    end

    // When full, a concurrent pop frees the slot being written.
    assign Fifo_Full = (count == CNT_FULL);
    assign Key_Valid = (count != '0);
    assign pop  = Key_Valid && Key_Ready;
    assign push = push_req && (!Fifo_Full || pop);
    assign head = mem[rptr];

    always_ff @(posedge Clk_K) begin
        if (push)
            mem[wptr] <= push_evt;
    end

    always_ff @(posedge Clk_K or negedge Reset_K) begin
        if (!Reset_K) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (push_req && !push)
                Overflow <= 1'b1;
            else if (Overflow_Clr)
                Overflow <= 1'b0;
        end
    end

    assign Key_Code  = Key_Valid ? head.code : 8'h00;
    assign Key_Ext   = Key_Valid && head.ext;
    assign Key_Break = Key_Valid && head.brk;

endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO depth in entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 50000, idle Clk_K cycles before a pending prefix is abandoned.
REQ-003 SHALL have port Clk_K  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port Reset_K  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Rx_Done  input  1  one-cycle strobe: ps2_Rx holds a new received byte.
REQ-006 SHALL have port ps2_Rx  input  8  scan-code byte from the PS/2 receiver.
REQ-007 SHALL have port Key_Ready  input  1  consumer accepts the head event this cycle.
REQ-008 SHALL have port Overflow_Clr  input  1  clears the Overflow flag.
REQ-009 SHALL have port Key_Valid  output  1  FIFO non-empty; head event presented.
REQ-010 SHALL have port Key_Code  output  8  head event scan code.
REQ-011 SHALL have port Key_Ext  output  1  head event had an E0 prefix.
REQ-012 SHALL have port Key_Break  output  1  head event had an F0 prefix (key release).
REQ-013 SHALL have port Fifo_Full  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port Overflow  output  1  sticky: an event was dropped.

Function
REQ-015 Decoder FSM SHALL have states IDLE, EXT, BRK, EXT_BRK, advancing only on Rx_Done=1 or timeout.
REQ-016 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {ext=0,brk=0,code}, stay IDLE.
REQ-017 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> push {ext=1,brk=0,code}, IDLE.
REQ-018 BRK: F0 -> stay BRK; E0 -> EXT_BRK; other -> push {ext=0,brk=1,code}, IDLE.
REQ-019 EXT_BRK: E0/F0 -> stay EXT_BRK; other -> push {ext=1,brk=1,code}, IDLE.
REQ-020 Bytes 00 and FF (receiver error codes) SHALL push nothing and force IDLE from any state.
REQ-021 Timeout counter SHALL clear on every Rx_Done and in IDLE; in non-IDLE state, reaching TIMEOUT-1 forces IDLE with no push.
REQ-022 FIFO entries SHALL be 10 bits {ext,brk,code}, first-word-fall-through: Key_Code/Key_Ext/Key_Break driven from head entry whenever Key_Valid=1.
REQ-023 Latency: Rx_Done at edge n producing a push into an empty FIFO SHALL give Key_Valid=1 after edge n+1 with that event.
REQ-024 Pop SHALL occur when Key_Valid=1 and Key_Ready=1; Key_Ready with Key_Valid=0 SHALL have no effect.
REQ-025 Push and pop in the same cycle SHALL both occur, including when full; occupancy unchanged.
REQ-026 Push when full without simultaneous pop SHALL drop the event, leave FIFO unchanged, and set Overflow.
REQ-027 Overflow SHALL stay set until Overflow_Clr=1 or reset; a drop coinciding with Overflow_Clr SHALL leave Overflow=1.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be clog2(DEPTH)+1 bits and never exceed DEPTH.
REQ-029 Events SHALL be delivered in arrival order, none duplicated.

Reset
REQ-030 Reset_K=0 SHALL asynchronously force FSM=IDLE, timeout counter=0, FIFO empty, pointers=0.
REQ-031 During reset Key_Valid=0, Key_Code=00, Key_Ext=0, Key_Break=0, Fifo_Full=0, Overflow=0.
REQ-032 Reset asserted mid-sequence (e.g. after F0) SHALL discard the prefix and all queued events.
REQ-033 Reset deassertion SHALL take effect at the next Clk_K edge; no event before a post-reset Rx_Done.

Verification
REQ-034 Reset: Reset_K=0 with Rx_Done pulses -> all outputs 0; release, Rx_Done 1C -> Key_Valid=1 one edge later, Key_Code=1C, Ext=0, Break=0.
REQ-035 Break/extended: F0,1C -> {1C,ext0,brk1}; E0,75 -> {75,1,0}; E0,F0,75 -> {75,1,1}; Key_Ready=1 drains all three in order.
REQ-036 Overflow: DEPTH=4, Key_Ready=0, makes 15,1D,24,2D,2C -> Fifo_Full=1 after 4th, Overflow=1 after 5th; drain yields 15,1D,24,2D only; Overflow_Clr -> 0.
REQ-037 Full push+pop: FIFO full, Key_Ready=1 and Rx_Done 33 same cycle -> head popped, 33 enqueued at tail, Fifo_Full stays 1, Overflow stays 0.
REQ-038 Timeout: F0, then no Rx_Done for TIMEOUT cycles, then 1C -> {1C,0,0}; repeat with gap TIMEOUT-2 -> {1C,0,1}.
REQ-039 Error byte: F0, FF, 1C -> single event {1C,0,0}; 00 alone in IDLE -> no event.
